instr_fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the decode controller.
- Holds the PC and fetches instructions over a request/grant/response memory port, with one request outstanding at a time.
- Presents each fetched instruction, its PC and the zero-extended opcode to decode through a one-entry valid/ready output buffer.
- Accepts jump/jal redirects from decode; a redirect flushes buffered and in-flight instructions.

---
 rtl/instr_fetch_unit.sv | 112 +++++++++++
 tb/tb_instr_fetch_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one memory request in flight and
// hands each instruction to decode through a one-entry valid/ready buffer.
module instr_fetch_unit #(
   parameter int          ADDR_W   = 13,
   parameter int          INSTR_W  = 16,
   parameter int unsigned RESET_PC = 0
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               id_valid,
   input  logic               id_ready,
   output logic [INSTR_W-1:0] id_instr,
   output logic [ADDR_W-1:0]  id_pc,
   output logic [ADDR_W-1:0]  id_pc_plus1,
   output logic [5:0]         id_opcode
);

   typedef enum logic [1:0] {
      S_FETCH   = 2'd0,
      S_WAIT    = 2'd1,
      S_DISCARD = 2'd2
   } state_t;

   state_t               r_state;
   logic [ADDR_W-1:0]    r_pc;
   logic [ADDR_W-1:0]    r_req_pc;
   logic                 r_id_valid;
   logic [INSTR_W-1:0]   r_id_instr;
   logic [ADDR_W-1:0]    r_id_pc;
   logic [5:0]           r_id_opcode;

   logic                 w_slot_free;
   logic                 w_req;
   logic                 w_capture;

   // A request is only issued when the buffer will be empty by the time its
   // response lands, so WAIT never coexists with a full buffer.
   assign w_slot_free = !r_id_valid || id_ready;
   assign w_req       = (r_state == S_FETCH) && w_slot_free && !redirect && !reset;
   assign w_capture   = (r_state == S_WAIT) && imem_rvalid && !redirect;

   // NOTE: state registers use non-blocking (<=) assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_FETCH;
         r_pc        <= ADDR_W'(RESET_PC);
         r_req_pc    <= '0;
         r_id_valid  <= 1'b0;
         r_id_instr  <= '0;
         r_id_pc     <= '0;
         r_id_opcode <= '0;
      end else if (redirect) begin
         // Flush: the buffer is emptied and any in-flight response is marked
         // for dropping; the state only leaves DISCARD once that response lands.
         r_pc       <= redirect_pc;
         r_id_valid <= 1'b0;
         case (r_state)
            S_FETCH:   r_state <= S_FETCH;
            S_WAIT:    r_state <= imem_rvalid ? S_FETCH : S_DISCARD;
            S_DISCARD: r_state <= imem_rvalid ? S_FETCH : S_DISCARD;
            default:   r_state <= S_FETCH;
         endcase
      end else begin
         case (r_state)
            S_FETCH: begin
               if (w_req && imem_gnt) begin
                  r_req_pc <= r_pc;
                  r_pc     <= r_pc + ADDR_W'(1);
                  r_state  <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  r_id_instr  <= imem_rdata;
                  r_id_pc     <= r_req_pc;
                  r_id_opcode <= {3'b000, imem_rdata[INSTR_W-1 -: 3]};
                  r_state     <= S_FETCH;
               end
            end
            S_DISCARD: begin
               if (imem_rvalid) begin
                  r_state <= S_FETCH;
               end
            end
            default: r_state <= S_FETCH;
         endcase

         if (w_capture) begin
            r_id_valid <= 1'b1;
         end else if (r_id_valid && id_ready) begin
            r_id_valid <= 1'b0;
         end
      end
   end

   assign imem_req    = w_req;
   assign imem_addr   = r_pc;
   assign id_valid    = r_id_valid;
   assign id_instr    = r_id_instr;
   assign id_pc       = r_id_pc;
   assign id_pc_plus1 = r_id_pc + ADDR_W'(1);
   assign id_opcode   = r_id_opcode;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, backpressure, redirects,
// PC wrap and reset during an outstanding request.
module tb_instr_fetch_unit;

   localparam int ADDR_W  = 13;
   localparam int INSTR_W = 16;

   logic               clk = 1'b0;
   logic               reset;
   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic               imem_gnt;
   logic               imem_rvalid;
   logic [INSTR_W-1:0] imem_rdata;
   logic               redirect;
   logic [ADDR_W-1:0]  redirect_pc;
   logic               id_valid;
   logic               id_ready;
   logic [INSTR_W-1:0] id_instr;
   logic [ADDR_W-1:0]  id_pc;
   logic [ADDR_W-1:0]  id_pc_plus1;
   logic [5:0]         id_opcode;

   int  checks = 0;
   int  errors = 0;
   logic auto_mem;

   instr_fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(0)) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .id_valid    (id_valid),
      .id_ready    (id_ready),
      .id_instr    (id_instr),
      .id_pc       (id_pc),
      .id_pc_plus1 (id_pc_plus1),
      .id_opcode   (id_opcode)
   );

   always #5 clk = ~clk;

   // Advance one clock; with auto_mem set, a grant in the finished cycle
   // produces a response (addr | 0x2000) in the new one.
   task automatic step();
      logic              granted;
      logic [ADDR_W-1:0] a;
      granted = imem_req && imem_gnt;
      a       = imem_addr;
      @(posedge clk);
      #1;
      if (auto_mem) begin
         imem_rvalid = granted;
         imem_rdata  = 16'h2000 | 16'(a);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
      redirect = 1'b0; redirect_pc = '0; id_ready = 1'b1; auto_mem = 1'b1;
      step();
      step();
      #1;
      checks++;
      if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
      checks++;
      if ({id_valid, id_instr, id_pc, id_opcode} !== '0)
         begin errors++; $display("FAIL reset_outputs: valid=%b instr=%h pc=%h op=%h want all 0", id_valid, id_instr, id_pc, id_opcode); end
      checks++;
      if (imem_addr !== 13'h0000) begin errors++; $display("FAIL reset_addr: got %h want 0000", imem_addr); end
   endtask

   // Cycles 1..6 after release: requests on odd cycles, captures visible on 3, 5.
   task automatic test_stream();
      reset = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         #1;
         checks++;
         if (imem_req !== c[0]) begin errors++; $display("FAIL stream_req c%0d: got %b want %b", c, imem_req, c[0]); end
         if (c[0]) begin
            checks++;
            if (imem_addr !== 13'((c - 1) / 2))
               begin errors++; $display("FAIL stream_addr c%0d: got %h want %h", c, imem_addr, 13'((c - 1) / 2)); end
         end
         checks++;
         if (id_valid !== (c >= 3 && c[0] == 1'b1))
            begin errors++; $display("FAIL stream_valid c%0d: got %b", c, id_valid); end
         if (c >= 3 && c[0] == 1'b1) begin
            checks++;
            if ({id_pc, id_opcode, id_instr} !== {13'((c - 3) / 2), 6'b000001, 16'h2000 | 16'((c - 3) / 2)})
               begin errors++; $display("FAIL stream_data c%0d: pc=%h op=%b instr=%h", c, id_pc, id_opcode, id_instr); end
         end
         step();
      end
   endtask

   // Cycle 7 holds pc=2 in the buffer; stall decode for 5 cycles.
   task automatic test_backpressure();
      id_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++;
         if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req k%0d: got %b want 0", k, imem_req); end
         checks++;
         if ({id_valid, id_pc, id_instr} !== {1'b1, 13'h0002, 16'h2002})
            begin errors++; $display("FAIL bp_hold k%0d: valid=%b pc=%h instr=%h want 1/0002/2002", k, id_valid, id_pc, id_instr); end
         step();
      end
      id_ready = 1'b1;
      #1;
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 13'h0003})
         begin errors++; $display("FAIL bp_release: req=%b addr=%h want 1/0003", imem_req, imem_addr); end
      auto_mem = 1'b0;
      step();
   endtask

   task automatic test_redirect_wait();
      imem_rvalid = 1'b0;
      redirect = 1'b1; redirect_pc = 13'h0100;
      #1;
      checks++;
      if (imem_req !== 1'b0) begin errors++; $display("FAIL rdw_req: got %b want 0", imem_req); end
      step();
      redirect = 1'b0;
      step();
      imem_rvalid = 1'b1; imem_rdata = 16'h2003;
      #1;
      checks++;
      if (imem_req !== 1'b0) begin errors++; $display("FAIL rdw_discard_req: got %b want 0", imem_req); end
      step();
      imem_rvalid = 1'b0;
      #1;
      checks++;
      if (id_valid !== 1'b0) begin errors++; $display("FAIL rdw_dropped: id_valid=%b want 0", id_valid); end
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 13'h0100})
         begin errors++; $display("FAIL rdw_target: req=%b addr=%h want 1/0100", imem_req, imem_addr); end
      auto_mem = 1'b1;
      step();
      step();
      #1;
      checks++;
      if ({id_valid, id_pc, id_pc_plus1, id_instr} !== {1'b1, 13'h0100, 13'h0101, 16'h2100})
         begin errors++; $display("FAIL rdw_fetch: valid=%b pc=%h pc1=%h instr=%h", id_valid, id_pc, id_pc_plus1, id_instr); end
      step();
   endtask

   // Entered in WAIT with the auto response (addr 0x101) present this cycle.
   task automatic test_redirect_rvalid();
      redirect = 1'b1; redirect_pc = 13'h0200;
      #1;
      checks++;
      if ({imem_rvalid, imem_req} !== 2'b10)
         begin errors++; $display("FAIL rdr_setup: rvalid=%b req=%b want 1/0", imem_rvalid, imem_req); end
      step();
      redirect = 1'b0;
      #1;
      checks++;
      if (id_valid !== 1'b0) begin errors++; $display("FAIL rdr_nocapture: id_valid=%b want 0", id_valid); end
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 13'h0200})
         begin errors++; $display("FAIL rdr_target: req=%b addr=%h want 1/0200", imem_req, imem_addr); end
      step();
      step();
      #1;
      checks++;
      if ({id_valid, id_pc} !== {1'b1, 13'h0200})
         begin errors++; $display("FAIL rdr_fetch: valid=%b pc=%h want 1/0200", id_valid, id_pc); end
   endtask

   task automatic test_wrap();
      redirect = 1'b1; redirect_pc = 13'h1FFF;
      #1;
      checks++;
      if (imem_req !== 1'b0) begin errors++; $display("FAIL wrap_fetch_block: req=%b want 0", imem_req); end
      step();
      redirect = 1'b0;
      #1;
      checks++;
      if ({id_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 13'h1FFF})
         begin errors++; $display("FAIL wrap_req: valid=%b req=%b addr=%h want 0/1/1FFF", id_valid, imem_req, imem_addr); end
      step();
      step();
      #1;
      checks++;
      if ({id_valid, id_pc, id_pc_plus1, id_instr, id_opcode} !== {1'b1, 13'h1FFF, 13'h0000, 16'h3FFF, 6'b000001})
         begin errors++; $display("FAIL wrap_fetch: valid=%b pc=%h pc1=%h instr=%h op=%b", id_valid, id_pc, id_pc_plus1, id_instr, id_opcode); end
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 13'h0000})
         begin errors++; $display("FAIL wrap_next: req=%b addr=%h want 1/0000", imem_req, imem_addr); end
      step();
   endtask

   // Entered in WAIT (request to 0x0000 outstanding); reset abandons it.
   task automatic test_reset_mid_wait();
      auto_mem = 1'b0; imem_rvalid = 1'b0; reset = 1'b1;
      #1;
      checks++;
      if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_wait_req: req=%b want 0", imem_req); end
      step();
      step();
      reset = 1'b0; imem_gnt = 1'b0;
      #1;
      checks++;
      if ({id_valid, id_instr, id_pc, id_pc_plus1, id_opcode} !== {1'b0, 16'h0000, 13'h0000, 13'h0001, 6'h00})
         begin errors++; $display("FAIL rst_wait_outputs: valid=%b instr=%h pc=%h pc1=%h op=%h", id_valid, id_instr, id_pc, id_pc_plus1, id_opcode); end
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 13'h0000})
         begin errors++; $display("FAIL rst_wait_first_req: req=%b addr=%h want 1/0000", imem_req, imem_addr); end
      step();
      imem_rvalid = 1'b1; imem_rdata = 16'h7FFF;
      #1;
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 13'h0000})
         begin errors++; $display("FAIL rst_hold_req: req=%b addr=%h want 1/0000", imem_req, imem_addr); end
      step();
      imem_rvalid = 1'b0; imem_gnt = 1'b1;
      #1;
      checks++;
      if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_stale_ignored: id_valid=%b want 0", id_valid); end
      auto_mem = 1'b1;
      step();
      step();
      #1;
      checks++;
      if ({id_valid, id_pc, id_instr} !== {1'b1, 13'h0000, 16'h2000})
         begin errors++; $display("FAIL rst_first_fetch: valid=%b pc=%h instr=%h want 1/0000/2000", id_valid, id_pc, id_instr); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_wait();
      test_redirect_rvalid();
      test_wrap();
      test_reset_mid_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
